id_ctrl_pipe: RTL and testbench
===============================

// Module: id_ctrl_pipe
// PURPOSE
//  Parametrised control-word delay line between ID and the execute/writeback stages.
//  Carries a WIDTH-bit control word per stage with valid and long-pipe tags.
//  Adds stall/flush, per-stage taps, and writeback-slot arbitration between short
//  and long (one extra stage) instructions. Replaces per-unit hand-written delay chains.
// PARAMETERS
//  WIDTH     32  control word width in bits
//  DEPTH     5   number of pipeline stages, >=2 (stage 1 = first register after ID)
//  WB_STAGE  3   1-based writeback stage for short instructions; 1 <= WB_STAGE < DEPTH
//  WE_BIT    0   bit index of the register-write-enable inside the control word
//  CNT_WIDTH 8   width of the saturating hazard counter
// PORTS
//  clk_i        in   1            clock, rising edge
//  reset_i      in   1            asynchronous, active-high reset
//  ctrl_i       in   WIDTH        decoded control word from ID
//  valid_i      in   1            ctrl_i holds a real instruction
//  long_i       in   1            instruction writes back at WB_STAGE+1 (long pipe)
//  stall_i      in   1            hold all stages; ctrl_i not captured
//  flush_i      in   DEPTH        per-stage squash mask, bit k-1 = stage k
//  stage_ctrl_o out  DEPTH*WIDTH  stage k word at [k*WIDTH-1 -: WIDTH], zero if stage invalid
//  stage_vld_o  out  DEPTH        per-stage valid
//  wb_ctrl_o    out  WIDTH        arbitrated writeback control word
//  wb_vld_o     out  1            wb_ctrl_o is live
//  wb_long_o    out  1            wb_ctrl_o taken from stage WB_STAGE+1
//  hazard_o     out  1            writeback collision this cycle (combinational)
//  hazard_cnt_o out  CNT_WIDTH    saturating count of collisions
// BEHAVIOUR
//  - Reset (async, reset_i=1): all stage data, valid and long tags = 0; hazard_cnt_o = 0.
//    All outputs therefore read 0 from reset assertion until first valid capture.
//  - Advance (stall_i=0): stage1 <= {ctrl_i, valid_i, long_i}; stage k <= stage k-1.
//    Latency: word with valid_i at edge t appears at stage k after k rising edges.
//  - Stall (stall_i=1): every stage holds data, valid and long tag; ctrl_i is dropped.
//  - Flush: at an edge, stage k with flush_i[k-1]=1 gets valid=0 in the next state.
//    Flush applies in both advance and stall. During an advance, bit k-1 squashes the
//    word entering stage k, not the one leaving it. flush_i[0] squashes the capture.
//    Flush wins over stall; data bits of squashed stages need not be cleared.
//  - Invalid stages output zero data on stage_ctrl_o; valid stages output stored data.
//  - Writeback arbitration (combinational from stage registers):
//    L = stage WB_STAGE+1 valid & long & word[WE_BIT]
//    S = stage WB_STAGE valid & !long
//    if L: wb_ctrl_o = stage WB_STAGE+1 word, wb_vld_o=1, wb_long_o=1
//    elif S: wb_ctrl_o = stage WB_STAGE word, wb_vld_o=1, wb_long_o=0
//    else: wb_ctrl_o=0, wb_vld_o=0, wb_long_o=0
//    A long instruction at WB_STAGE never drives writeback. A long instruction at
//    WB_STAGE+1 with WE=0 yields the slot to S.
//  - Hazard: hazard_o = L & S & stage WB_STAGE word[WE_BIT]. The long word wins;
//    the short write is lost. This is flagged, not stopped.
//  - hazard_cnt_o increments on each edge with hazard_o=1 and stall_i=0.
//    It saturates at 2^CNT_WIDTH-1. A stalled collision counts once, when released.
//  - Reset mid-operation: all in-flight words are discarded immediately (async).
//    The counter clears. The first capture happens on the first edge after release.
//  - No internal FSM beyond the shift/valid state. All arithmetic is unsigned.
// TESTING
//  - Reset/latency: reset; valid_i=1, ctrl_i=0xA5A5_0001, 1 edge of valid, DEPTH=5.
//    -> stage_vld_o=00001,00010,...,10000 on successive edges; wb_ctrl_o=0xA5A5_0001
//    after edge 3.
//  - Stall: word 0x11 at stage 2, stall_i=1 for 3 edges with ctrl_i=0x22.
//    -> stage 2 still 0x11 and 0x22 never captured; after release 0x11 reaches stage 3
//    on the next edge.
//  - Flush: words 0x1,0x2,0x3 at stages 1..3, flush_i=5'b00110 for one edge.
//    -> next state: stage 1 holds the new ctrl_i; stages 2,3 invalid (zero out);
//    stage 4 = 0x3.
//  - Long vs short: long WE=1 word 0xF1 issued, short WE=1 word 0x01 issued next cycle.
//    -> hazard_o=1 for one cycle with wb_ctrl_o=0xF1, wb_long_o=1; hazard_cnt_o=1.
//    -> same with long WE=0: hazard_o=0, wb_ctrl_o=0x01.
//  - Saturation: CNT_WIDTH=2, force 5 collisions -> hazard_cnt_o = 3 and stays 3.
//  - Async reset mid-flight: assert reset_i between clock edges while stages are full.
//    -> all stage_vld_o and wb_vld_o drop to 0 before the next edge; hazard_cnt_o=0.

Source files
------------

// File: rtl/id_ctrl_pipe.sv
// Control-word delay line from ID to execute/writeback with per-stage taps,
// stall/flush, and arbitration of the writeback slot between short and long ops.
module id_ctrl_pipe #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 5,
    parameter int WB_STAGE  = 3,
    parameter int WE_BIT    = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [WIDTH-1:0]       ctrl_i,
    input  logic                   valid_i,
    input  logic                   long_i,
    input  logic                   stall_i,
    input  logic [DEPTH-1:0]       flush_i,
    output logic [DEPTH*WIDTH-1:0] stage_ctrl_o,
    output logic [DEPTH-1:0]       stage_vld_o,
    output logic [WIDTH-1:0]       wb_ctrl_o,
    output logic                   wb_vld_o,
    output logic                   wb_long_o,
    output logic                   hazard_o,
    output logic [CNT_WIDTH-1:0]   hazard_cnt_o
);

    localparam int SI = WB_STAGE - 1;
    localparam int LI = WB_STAGE;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            lng_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic                        l_sel;
    logic                        s_sel;

    // Flush masks the word entering each stage, so it applies after the shift.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= '0;
            vld_q  <= '0;
            lng_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (!stall_i) begin
                data_q[0] <= ctrl_i;
                vld_q[0]  <= valid_i & ~flush_i[0];
                lng_q[0]  <= long_i;
                for (int k = 1; k < DEPTH; k++) begin
                    data_q[k] <= data_q[k-1];
                    vld_q[k]  <= vld_q[k-1] & ~flush_i[k];
                    lng_q[k]  <= lng_q[k-1];
                end
            end else begin
                vld_q <= vld_q & ~flush_i;
            end
            if (hazard_o && !stall_i && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign stage_ctrl_o[g*WIDTH +: WIDTH] = vld_q[g] ? data_q[g] : '0;
    end

    assign stage_vld_o  = vld_q;
    assign hazard_cnt_o = cnt_q;

    assign l_sel    = vld_q[LI] & lng_q[LI] & data_q[LI][WE_BIT];
    assign s_sel    = vld_q[SI] & ~lng_q[SI];
    assign hazard_o = l_sel & s_sel & data_q[SI][WE_BIT];

    always_comb begin
        wb_ctrl_o = '0;
        wb_vld_o  = 1'b0;
        wb_long_o = 1'b0;
        if (l_sel) begin
            wb_ctrl_o = data_q[LI];
            wb_vld_o  = 1'b1;
            wb_long_o = 1'b1;
        end else if (s_sel) begin
            wb_ctrl_o = data_q[SI];
            wb_vld_o  = 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: latency, stall, flush, writeback
// arbitration, counter saturation and asynchronous reset.
module tb_id_ctrl_pipe;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [31:0]  ctrl_i;
    logic         valid_i;
    logic         long_i;
    logic         stall_i;
    logic [4:0]   flush_i;

    logic [159:0] stage_ctrl;
    logic [4:0]   stage_vld;
    logic [31:0]  wb_ctrl;
    logic         wb_vld;
    logic         wb_long;
    logic         hazard;
    logic [7:0]   hazard_cnt;

    logic [159:0] s_stage_ctrl;
    logic [4:0]   s_stage_vld;
    logic [31:0]  s_wb_ctrl;
    logic         s_wb_vld;
    logic         s_wb_long;
    logic         s_hazard;
    logic [1:0]   s_hazard_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    id_ctrl_pipe u_dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ctrl_i       (ctrl_i),
        .valid_i      (valid_i),
        .long_i       (long_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stage_ctrl_o (stage_ctrl),
        .stage_vld_o  (stage_vld),
        .wb_ctrl_o    (wb_ctrl),
        .wb_vld_o     (wb_vld),
        .wb_long_o    (wb_long),
        .hazard_o     (hazard),
        .hazard_cnt_o (hazard_cnt)
    );

    id_ctrl_pipe #(.CNT_WIDTH(2)) u_sat (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ctrl_i       (ctrl_i),
        .valid_i      (valid_i),
        .long_i       (long_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stage_ctrl_o (s_stage_ctrl),
        .stage_vld_o  (s_stage_vld),
        .wb_ctrl_o    (s_wb_ctrl),
        .wb_vld_o     (s_wb_vld),
        .wb_long_o    (s_wb_long),
        .hazard_o     (s_hazard),
        .hazard_cnt_o (s_hazard_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sw(input int k);
        return stage_ctrl[(k-1)*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] c, input logic v, input logic l);
        ctrl_i  = c;
        valid_i = v;
        long_i  = l;
        tick();
    endtask

    task automatic drain();
        repeat (6) issue(32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_i = 1'b1;
        ctrl_i  = '0;
        valid_i = 1'b0;
        long_i  = 1'b0;
        stall_i = 1'b0;
        flush_i = '0;
        #12;
        check("rst_vld", 32'(stage_vld), 32'h0);
        check("rst_wbvld", 32'(wb_vld), 32'h0);
        check("rst_cnt", 32'(hazard_cnt), 32'h0);
        check("rst_ctrl", stage_ctrl[31:0], 32'h0);
        reset_i = 1'b0;

        // latency
        issue(32'hA5A5_0001, 1'b1, 1'b0);
        check("lat_e1", 32'(stage_vld), 32'h01);
        check("lat_e1_wb", 32'(wb_vld), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            issue(32'h0, 1'b0, 1'b0);
            check($sformatf("lat_e%0d", k), 32'(stage_vld), 32'(1 << (k-1)));
            if (k == 3) begin
                check("lat_wb_ctrl", wb_ctrl, 32'hA5A5_0001);
                check("lat_wb_vld", 32'(wb_vld), 32'h1);
                check("lat_wb_long", 32'(wb_long), 32'h0);
            end
        end
        drain();

        // stall
        issue(32'h11, 1'b1, 1'b0);
        issue(32'h0, 1'b0, 1'b0);
        stall_i = 1'b1;
        ctrl_i  = 32'h22;
        valid_i = 1'b1;
        repeat (3) tick();
        check("stall_s2", sw(2), 32'h11);
        check("stall_vld", 32'(stage_vld), 32'h02);
        stall_i = 1'b0;
        valid_i = 1'b0;
        tick();
        check("stall_rel_s3", sw(3), 32'h11);
        check("stall_rel_vld", 32'(stage_vld), 32'h04);
        drain();

        // flush
        issue(32'h3, 1'b1, 1'b0);
        issue(32'h2, 1'b1, 1'b0);
        issue(32'h1, 1'b1, 1'b0);
        flush_i = 5'b00110;
        issue(32'h4, 1'b1, 1'b0);
        flush_i = '0;
        check("flush_vld", 32'(stage_vld), 32'h09);
        check("flush_s1", sw(1), 32'h4);
        check("flush_s2", sw(2), 32'h0);
        check("flush_s3", sw(3), 32'h0);
        check("flush_s4", sw(4), 32'h3);
        drain();

        // long WE=1 vs short WE=1
        issue(32'hF1, 1'b1, 1'b1);
        issue(32'h01, 1'b1, 1'b0);
        issue(32'h0, 1'b0, 1'b0);
        check("long_at_wb", 32'(wb_vld), 32'h0);
        issue(32'h0, 1'b0, 1'b0);
        check("hz_flag", 32'(hazard), 32'h1);
        check("hz_wb_ctrl", wb_ctrl, 32'hF1);
        check("hz_wb_long", 32'(wb_long), 32'h1);
        issue(32'h0, 1'b0, 1'b0);
        check("hz_flag_off", 32'(hazard), 32'h0);
        check("hz_cnt", 32'(hazard_cnt), 32'h1);
        drain();

        // long WE=0 yields the slot
        issue(32'hF0, 1'b1, 1'b1);
        issue(32'h01, 1'b1, 1'b0);
        issue(32'h0, 1'b0, 1'b0);
        issue(32'h0, 1'b0, 1'b0);
        check("nowe_hz", 32'(hazard), 32'h0);
        check("nowe_wb_ctrl", wb_ctrl, 32'h01);
        check("nowe_wb_long", 32'(wb_long), 32'h0);
        check("nowe_wb_vld", 32'(wb_vld), 32'h1);
        issue(32'h0, 1'b0, 1'b0);
        check("nowe_cnt", 32'(hazard_cnt), 32'h1);
        drain();

        // async reset mid-flight
        repeat (5) issue(32'h55, 1'b1, 1'b0);
        check("full_vld", 32'(stage_vld), 32'h1F);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_vld", 32'(stage_vld), 32'h0);
        check("arst_wbvld", 32'(wb_vld), 32'h0);
        check("arst_cnt", 32'(hazard_cnt), 32'h0);
        check("arst_sat_vld", 32'(s_stage_vld), 32'h0);
        #1;
        reset_i = 1'b0;
        issue(32'h77, 1'b1, 1'b0);
        check("arst_first", 32'(stage_vld), 32'h01);
        check("arst_first_d", sw(1), 32'h77);
        drain();

        // saturation: five collisions
        for (int i = 0; i < 5; i++) begin
            issue(32'hF1, 1'b1, 1'b1);
            issue(32'h01, 1'b1, 1'b0);
        end
        drain();
        check("sat_main", 32'(hazard_cnt), 32'h5);
        check("sat_cnt", 32'(s_hazard_cnt), 32'h3);
        issue(32'hF1, 1'b1, 1'b1);
        issue(32'h01, 1'b1, 1'b0);
        drain();
        check("sat_main6", 32'(hazard_cnt), 32'h6);
        check("sat_hold", 32'(s_hazard_cnt), 32'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
